// File: rtl/multi_data_sync.sv
// Multi-channel bus synchroniser: each channel syncs its enable/toggle qualifier,
// captures its source bus on the detected event and tracks valid/ack/overrun.
module multi_data_sync #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 4,
  parameter int TOGGLE_MODE = 0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0]   unsync_bus,
  input  logic [NUM_CH-1:0]             bus_enable,
  input  logic [NUM_CH-1:0]             sync_ack,
  input  logic [NUM_CH-1:0]             overrun_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0]   sync_bus,
  output logic [NUM_CH-1:0]             enable_pulse,
  output logic [NUM_CH-1:0]             sync_valid,
  output logic [NUM_CH-1:0]             overrun
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_STAGES-1:0] sync_ff;
    logic                  prev;
    logic                  sync_last;
    logic                  evt;
    logic [BUS_WIDTH-1:0]  data_q;
    logic                  pulse_q;
    logic                  valid_q;
    logic                  ovr_q;

    assign sync_last = sync_ff[NUM_STAGES-1];
    assign evt       = (TOGGLE_MODE != 0) ? (sync_last ^ prev) : (sync_last & ~prev);

    always_ff @(posedge CLK) begin
      if (RST) begin
        sync_ff <= '0;
        prev    <= 1'b0;
      end else begin
        sync_ff <= {sync_ff[NUM_STAGES-2:0], bus_enable[c]};
        prev    <= sync_last;
      end
    end

    // A simultaneous ack keeps valid set and suppresses overrun; a new overrun beats its clear.
    always_ff @(posedge CLK) begin
      if (RST) begin
        data_q  <= '0;
        pulse_q <= 1'b0;
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        pulse_q <= evt;
        if (evt) begin
          data_q <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
        end
        if (evt) begin
          valid_q <= 1'b1;
        end else if (sync_ack[c]) begin
          valid_q <= 1'b0;
        end
        if (evt && valid_q && !sync_ack[c]) begin
          ovr_q <= 1'b1;
        end else if (overrun_clr[c]) begin
          ovr_q <= 1'b0;
        end
      end
    end

    assign sync_bus[c*BUS_WIDTH +: BUS_WIDTH] = data_q;
    assign enable_pulse[c]                    = pulse_q;
    assign sync_valid[c]                      = valid_q;
    assign overrun[c]                         = ovr_q;
  end

endmodule

// File: tb/tb_multi_data_sync.sv
// Bench for multi_data_sync: a level-mode (2-stage) and a toggle-mode (3-stage) instance
// checked every cycle against an edge-history reference model, plus directed checks.
module tb_multi_data_sync;
  localparam int NUM_CH = 4;
  localparam int BW     = 8;
  localparam int MAXE   = 2048;

  logic                 clk_tb = 1'b0;
  logic                 rst          [2];
  logic [NUM_CH*BW-1:0] ubus         [2];
  logic [NUM_CH-1:0]    en           [2];
  logic [NUM_CH-1:0]    ack          [2];
  logic [NUM_CH-1:0]    clr          [2];
  logic [NUM_CH*BW-1:0] sbus         [2];
  logic [NUM_CH-1:0]    pulse        [2];
  logic [NUM_CH-1:0]    valid        [2];
  logic [NUM_CH-1:0]    ovr          [2];

  int compared   = 0;
  int mismatched = 0;

  // Reference model: enable samples per edge, last reset edge, and per-channel results.
  bit          hist     [2][NUM_CH][MAXE];
  int          last_rst [2];
  int          edge_idx = -1;
  logic [BW-1:0] m_data [2][NUM_CH];
  logic        m_pulse  [2][NUM_CH];
  logic        m_valid  [2][NUM_CH];
  logic        m_ovr    [2][NUM_CH];

  always #5 clk_tb = ~clk_tb;

  multi_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(BW), .NUM_CH(NUM_CH), .TOGGLE_MODE(0)) dut_lvl (
    .CLK(clk_tb), .RST(rst[0]), .unsync_bus(ubus[0]), .bus_enable(en[0]),
    .sync_ack(ack[0]), .overrun_clr(clr[0]), .sync_bus(sbus[0]),
    .enable_pulse(pulse[0]), .sync_valid(valid[0]), .overrun(ovr[0])
  );

  multi_data_sync #(.NUM_STAGES(3), .BUS_WIDTH(BW), .NUM_CH(NUM_CH), .TOGGLE_MODE(1)) dut_tgl (
    .CLK(clk_tb), .RST(rst[1]), .unsync_bus(ubus[1]), .bus_enable(en[1]),
    .sync_ack(ack[1]), .overrun_clr(clr[1]), .sync_bus(sbus[1]),
    .enable_pulse(pulse[1]), .sync_valid(valid[1]), .overrun(ovr[1])
  );

  // Enable value as seen by the synchroniser at edge j; reset wipes everything up to its edge.
  function automatic bit sample(int d, int c, int j);
    if (j < 0 || j <= last_rst[d]) return 1'b0;
    return hist[d][c][j];
  endfunction

  // The event seen just before edge k comes from samples taken NUM_STAGES and NUM_STAGES+1 edges earlier.
  task automatic model_update();
    int  ns;
    bit  a, b, evt;
    edge_idx++;
    for (int d = 0; d < 2; d++) begin
      ns = (d == 0) ? 2 : 3;
      for (int c = 0; c < NUM_CH; c++) hist[d][c][edge_idx] = en[d][c];
      if (rst[d]) begin
        last_rst[d] = edge_idx;
        for (int c = 0; c < NUM_CH; c++) begin
          m_data[d][c] = '0; m_pulse[d][c] = 0; m_valid[d][c] = 0; m_ovr[d][c] = 0;
        end
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          a   = sample(d, c, edge_idx - ns);
          b   = sample(d, c, edge_idx - ns - 1);
          evt = (d == 1) ? (a ^ b) : (a & ~b);
          if (evt && m_valid[d][c] && !ack[d][c]) m_ovr[d][c] = 1;
          else if (clr[d][c])                     m_ovr[d][c] = 0;
          if (evt)            m_valid[d][c] = 1;
          else if (ack[d][c]) m_valid[d][c] = 0;
          if (evt) m_data[d][c] = ubus[d][c*BW +: BW];
          m_pulse[d][c] = evt;
        end
      end
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("e%0d_d%0d_c%0d_bus", edge_idx, d, c), 32'(sbus[d][c*BW +: BW]), 32'(m_data[d][c]));
        check($sformatf("e%0d_d%0d_c%0d_pulse", edge_idx, d, c), 32'(pulse[d][c]), 32'(m_pulse[d][c]));
        check($sformatf("e%0d_d%0d_c%0d_valid", edge_idx, d, c), 32'(valid[d][c]), 32'(m_valid[d][c]));
        check($sformatf("e%0d_d%0d_c%0d_ovr", edge_idx, d, c), 32'(ovr[d][c]), 32'(m_ovr[d][c]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_tb);
    model_update();
    @(negedge clk_tb);
    check_model();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1; ubus[d] = '0; en[d] = '0; ack[d] = '0; clr[d] = '0; last_rst[d] = -1;
    end
    tick(); tick();
    check("reset_pulse", 32'(pulse[0]), 32'h0);
    check("reset_bus", sbus[0], 32'h0);
    rst[0] = 0; rst[1] = 0;

    // Level mode, channel 0 basic capture
    ubus[0][7:0] = 8'h08; en[0][0] = 1;
    tick(); tick();
    check("lvl_e2_pulse", 32'(pulse[0]), 32'h0);
    tick();
    check("lvl_e3_pulse", 32'(pulse[0]), 32'h1);
    check("lvl_e3_bus", sbus[0], 32'h0000_0008);
    check("lvl_e3_valid", 32'(valid[0]), 32'h1);
    tick();
    check("lvl_e4_pulse", 32'(pulse[0]), 32'h0);
    check("lvl_e4_valid", 32'(valid[0]), 32'h1);

    // Ack, then overrun by two unacknowledged captures
    ack[0][0] = 1; tick(); ack[0][0] = 0;
    check("ack_drop_valid", 32'(valid[0]), 32'h0);
    en[0][0] = 0; repeat (3) tick();
    ubus[0][7:0] = 8'hA5; en[0][0] = 1; repeat (3) tick();
    check("a5_valid", 32'(valid[0]), 32'h1);
    check("a5_ovr", 32'(ovr[0]), 32'h0);
    en[0][0] = 0; repeat (3) tick();
    ubus[0][7:0] = 8'h3C; en[0][0] = 1; repeat (3) tick();
    check("3c_bus", sbus[0], 32'h0000_003C);
    check("3c_ovr", 32'(ovr[0]), 32'h1);
    ack[0][0] = 1; tick(); ack[0][0] = 0;
    check("3c_ack_valid", 32'(valid[0]), 32'h0);
    clr[0][0] = 1; tick(); clr[0][0] = 0;
    check("ovr_clr", 32'(ovr[0]), 32'h0);

    // Ack coinciding with an event, then clear coinciding with an overrun
    en[0][0] = 0; repeat (3) tick();
    ubus[0][7:0] = 8'h5A; en[0][0] = 1; repeat (3) tick();
    en[0][0] = 0; repeat (3) tick();
    ubus[0][7:0] = 8'h77; en[0][0] = 1; tick(); tick();
    ack[0][0] = 1; tick(); ack[0][0] = 0;
    check("simack_valid", 32'(valid[0]), 32'h1);
    check("simack_ovr", 32'(ovr[0]), 32'h0);
    check("simack_bus", sbus[0], 32'h0000_0077);
    en[0][0] = 0; repeat (3) tick();
    ubus[0][7:0] = 8'h99; en[0][0] = 1; tick(); tick();
    clr[0][0] = 1; tick(); clr[0][0] = 0;
    check("simclr_ovr", 32'(ovr[0]), 32'h1);

    // Toggle mode, 3 stages, channel 2
    ubus[1][23:16] = 8'h11; en[1][2] = 1;
    repeat (3) tick();
    check("tgl1_e3_pulse", 32'(pulse[1]), 32'h0);
    tick();
    check("tgl1_e4_pulse", 32'(pulse[1]), 32'h4);
    check("tgl1_bus", sbus[1], 32'h0011_0000);
    ubus[1][23:16] = 8'h22; en[1][2] = 0;
    repeat (3) tick();
    check("tgl2_e3_pulse", 32'(pulse[1]), 32'h0);
    tick();
    check("tgl2_e4_pulse", 32'(pulse[1]), 32'h4);
    check("tgl2_bus", sbus[1], 32'h0022_0000);
    check("tgl2_ovr", 32'(ovr[1]), 32'h4);

    // Reset one edge after a level rise on channel 1; channel 0 enable stays high throughout
    en[0][1] = 1; tick();
    rst[0] = 1; tick();
    check("midrst_pulse", 32'(pulse[0]), 32'h0);
    check("midrst_valid", 32'(valid[0]), 32'h0);
    check("midrst_ovr", 32'(ovr[0]), 32'h0);
    check("midrst_bus", sbus[0], 32'h0);
    rst[0] = 0; tick(); tick();
    check("midrst_r2_pulse", 32'(pulse[0]), 32'h0);
    tick();
    check("midrst_r3_pulse", 32'(pulse[0]), 32'h3);
    tick();
    check("midrst_r4_pulse", 32'(pulse[0]), 32'h0);

    // Staggered enables on all channels
    en[0] = '0; rst[0] = 1; tick(); rst[0] = 0;
    ubus[0] = 32'h0403_0201;
    en[0] = 4'b0001; tick();
    en[0] = 4'b0011; tick();
    en[0] = 4'b0111; tick();
    check("stag_ch0", 32'(pulse[0]), 32'h1);
    en[0] = 4'b1111; tick();
    check("stag_ch1", 32'(pulse[0]), 32'h2);
    tick();
    check("stag_ch2", 32'(pulse[0]), 32'h4);
    tick();
    check("stag_ch3", 32'(pulse[0]), 32'h8);
    check("stag_bus", sbus[0], 32'h0403_0201);

    // Random traffic on both instances, model checks every cycle
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d]  = ($urandom_range(0, 49) == 0);
        ubus[d] = $urandom;
        en[d]   = (en[d] ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
        ack[d]  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        clr[d]  = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
